io_input_ctrl: RTL and testbench
================================

IO_INPUT_CTRL -- requirements
Module: io_input_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DBITS, 32, bus data width.
- DEBOUNCE_CYCLES, 100000, consecutive cycles a synchronized input group must differ from its stable value before it is accepted; minimum 2.
- ADDR_KEY, 32'hF0000010, address of the KDATA register.
- ADDR_SW, 32'hF0000014, address of the SDATA register.
- ADDR_KCTRL, 32'hF0000110, address of the KCTRL register.
- ADDR_SCTRL, 32'hF0000114, address of the SCTRL register.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-low.
- addr, in, 32, bus address from the processor data path.
- rdEn, in, 1, read strobe, valid for one cycle.
- wrEn, in, 1, write strobe.
- dataIn, in, 32, write data.
- KEY, in, 4, raw asynchronous push-button pins.
- SW, in, 10, raw asynchronous switch pins.
- dataOut, out, 32, read data.
- intr, out, 1, level interrupt request.

Function
REQ-003 Each of KEY and SW SHALL pass through a two-flop synchronizer; no inversion is applied.
REQ-004 There SHALL be one debounce counter per group; each cycle, sync==stable -> counter cleared; sync!=stable and counter<DEBOUNCE_CYCLES-1 -> counter increments; sync!=stable and counter==DEBOUNCE_CYCLES-1 -> stable loads sync and counter clears.
REQ-005 Latency: a pin change held steady SHALL appear in KDATA/SDATA exactly 2+DEBOUNCE_CYCLES rising edges after it is first sampled; a glitch shorter than DEBOUNCE_CYCLES SHALL never change stable.
REQ-006 KDATA SHALL read as {28'b0, keyStable} and SDATA as {22'b0, swStable}.
REQ-007 KCTRL/SCTRL fields: bit0 RDY, bit2 OVR, bit8 IE; all other bits read 0.
REQ-008 Any update of a group's stable value SHALL set RDY; if RDY was already 1 and is not being cleared in the same cycle, OVR SHALL also be set.
REQ-009 rdEn with addr==ADDR_KEY (ADDR_SW) SHALL clear the corresponding RDY; a simultaneous stable update takes priority, so RDY stays 1 and OVR is not set.
REQ-010 A write to a CTRL register SHALL load IE from dataIn[8], clear OVR if dataIn[2]==0, and ignore dataIn[0]; a simultaneous new overrun takes priority, so OVR is set to 1.
REQ-011 Writes to KDATA/SDATA and to unmapped addresses SHALL be ignored.
REQ-012 dataOut SHALL be combinational from addr irrespective of rdEn, and SHALL be 0 for unmapped addresses.
REQ-013 intr SHALL be registered: intr = (kRDY&kIE)|(sRDY&sIE), taken from the previous cycle's state.

Reset
REQ-014 When reset==0 at a clock edge, the following SHALL occur:
- KEY synchronizer and keyStable load 4'hF;
- SW synchronizer and swStable load 0;
- counters, RDY, OVR, IE and intr load 0.
REQ-015 Reset asserted mid-debounce SHALL discard the partial count; no RDY is raised by reset itself.

Configuration
REQ-016 Macro IO_INPUT_SW_DEBOUNCE_EN defined -> SW is debounced per REQ-004.
REQ-017 Macro IO_INPUT_SW_DEBOUNCE_EN undefined -> swStable loads the SW synchronizer output every cycle (latency 3 edges), the SW counter is absent, and SCTRL RDY/OVR follow every change per REQ-008.

Verification (DEBOUNCE_CYCLES=4, macro defined)
REQ-018 KEY 4'hF->4'hE held -> KDATA=0xE exactly 6 edges later, kRDY=1, read at ADDR_KEY -> kRDY=0.
REQ-019 KEY 4'hF->4'hE for 3 cycles, then back to 4'hF -> KDATA stays 0xF, kRDY stays 0.
REQ-020 Two SW changes accepted with no intervening read (0x000->0x001->0x003) -> SCTRL reads 0x5; write 0x000 to ADDR_SCTRL -> 0x1.
REQ-021 Read of ADDR_KEY in the same cycle a new KEY value is accepted -> kRDY=1, kOVR=0.
REQ-022 Write 0x100 to ADDR_KCTRL, then accept a KEY change -> intr=1 one cycle after kRDY rises; read at ADDR_KEY -> intr=0 one cycle after kRDY clears.
REQ-023 reset=0 mid-debounce with SW held at 0x3FF -> after release, SDATA=0x000 and SCTRL=0 until 6 edges later, then SDATA=0x3FF.

Source files
------------

// File: rtl/io_input_ctrl.sv
// -----------------------------------------------------------------------------
// io_input_ctrl
//
// Memory-mapped input controller for four push buttons (KEY) and ten switches
// (SW). Each pin group is synchronized with two flops, debounced, and exposed
// through a data register (KDATA/SDATA) and a control register (KCTRL/SCTRL)
// holding RDY (bit 0), OVR (bit 2) and IE (bit 8). A registered level
// interrupt is raised while any group has RDY and IE both set.
//
// Build option:
//   IO_INPUT_SW_DEBOUNCE_EN  defined   -> SW uses the same debounce counter as KEY
//                            undefined -> SW stable value follows the
//                                         synchronizer every cycle
//
// Ports:
//   clk      sole clock, rising edge
//   reset    synchronous, active-low
//   addr     bus address
//   rdEn     one-cycle read strobe (clears RDY of the data register read)
//   wrEn     write strobe (only the CTRL registers are writable)
//   dataIn   write data
//   KEY      raw asynchronous push-button pins
//   SW       raw asynchronous switch pins
//   dataOut  combinational read data selected by addr
//   intr     registered interrupt request
// -----------------------------------------------------------------------------
module io_input_ctrl #(
  parameter int          DBITS           = 32,
  parameter int          DEBOUNCE_CYCLES = 100000,
  parameter logic [31:0] ADDR_KEY        = 32'hF0000010,
  parameter logic [31:0] ADDR_SW         = 32'hF0000014,
  parameter logic [31:0] ADDR_KCTRL      = 32'hF0000110,
  parameter logic [31:0] ADDR_SCTRL      = 32'hF0000114
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic             rdEn,
  input  logic             wrEn,
  input  logic [DBITS-1:0] dataIn,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [DBITS-1:0] dataOut,
  output logic             intr
);

  // Wide enough to hold DEBOUNCE_CYCLES-1, the last count before acceptance.
  localparam int            CW      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    key_meta;
  logic [3:0]    key_sync;
  logic [3:0]    key_stable;
  logic [CW-1:0] key_cnt;
  logic          key_upd;

  logic [9:0]    sw_meta;
  logic [9:0]    sw_sync;
  logic [9:0]    sw_stable;
  logic          sw_upd;

  logic          k_rdy, k_ovr, k_ie;
  logic          s_rdy, s_ovr, s_ie;

  logic          rd_key, rd_sw, wr_kctrl, wr_sctrl;
  logic          k_new_ovr, s_new_ovr;

  // Only IE, OVR-clear and (ignored) RDY bits of the write data are meaningful.
  logic          unused_data_bits;
  assign unused_data_bits = ^{dataIn[DBITS-1:9], dataIn[7:3], dataIn[1:0]};

  // KEY: two-flop synchronizer followed by the debounce counter. The idle
  // level of the buttons is high, so everything restarts at 4'hF.
  assign key_upd = (key_sync != key_stable) && (key_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_meta   <= 4'hF;
      key_sync   <= 4'hF;
      key_stable <= 4'hF;
      key_cnt    <= '0;
    end else begin
      key_meta <= KEY;
      key_sync <= key_meta;
      if (key_sync == key_stable) begin
        key_cnt <= '0;
      end else if (key_upd) begin
        key_stable <= key_sync;
        key_cnt    <= '0;
      end else begin
        key_cnt <= key_cnt + 1'b1;
      end
    end
  end

`ifdef IO_INPUT_SW_DEBOUNCE_EN
  logic [CW-1:0] sw_cnt;

  assign sw_upd = (sw_sync != sw_stable) && (sw_cnt == CNT_MAX);

  // SW: same synchronize-then-debounce path as KEY, idle level 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      sw_stable <= '0;
      sw_cnt    <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
      if (sw_sync == sw_stable) begin
        sw_cnt <= '0;
      end else if (sw_upd) begin
        sw_stable <= sw_sync;
        sw_cnt    <= '0;
      end else begin
        sw_cnt <= sw_cnt + 1'b1;
      end
    end
  end
`else
  assign sw_upd = (sw_sync != sw_stable);

  // SW without debounce: the stable copy tracks the synchronizer, and any
  // difference between the two is a new value being accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      sw_stable <= '0;
    end else begin
      sw_meta   <= SW;
      sw_sync   <= sw_meta;
      sw_stable <= sw_sync;
    end
  end
`endif

  assign rd_key   = rdEn && (addr == ADDR_KEY);
  assign rd_sw    = rdEn && (addr == ADDR_SW);
  assign wr_kctrl = wrEn && (addr == ADDR_KCTRL);
  assign wr_sctrl = wrEn && (addr == ADDR_SCTRL);

  // An overrun is a second accepted value while the first is still unread; a
  // read in the same cycle consumes the old value, so it is not an overrun.
  assign k_new_ovr = key_upd && k_rdy && !rd_key;
  assign s_new_ovr = sw_upd  && s_rdy && !rd_sw;

  // Status bits: a new value beats a clearing read, a new overrun beats a
  // clearing write. The interrupt is registered from the pre-edge status.
  always_ff @(posedge clk) begin
    if (!reset) begin
      k_rdy <= 1'b0;
      k_ovr <= 1'b0;
      k_ie  <= 1'b0;
      s_rdy <= 1'b0;
      s_ovr <= 1'b0;
      s_ie  <= 1'b0;
      intr  <= 1'b0;
    end else begin
      intr <= (k_rdy & k_ie) | (s_rdy & s_ie);

      if (key_upd)     k_rdy <= 1'b1;
      else if (rd_key) k_rdy <= 1'b0;

      if (sw_upd)     s_rdy <= 1'b1;
      else if (rd_sw) s_rdy <= 1'b0;

      if (k_new_ovr)                 k_ovr <= 1'b1;
      else if (wr_kctrl && !dataIn[2]) k_ovr <= 1'b0;

      if (s_new_ovr)                 s_ovr <= 1'b1;
      else if (wr_sctrl && !dataIn[2]) s_ovr <= 1'b0;

      if (wr_kctrl) k_ie <= dataIn[8];
      if (wr_sctrl) s_ie <= dataIn[8];
    end
  end

  // Read mux is purely address-driven so the data path can sample it in the
  // same cycle it presents the address.
  always_comb begin
    dataOut = '0;
    if (addr == ADDR_KEY) begin
      dataOut[3:0] = key_stable;
    end else if (addr == ADDR_SW) begin
      dataOut[9:0] = sw_stable;
    end else if (addr == ADDR_KCTRL) begin
      dataOut[0] = k_rdy;
      dataOut[2] = k_ovr;
      dataOut[8] = k_ie;
    end else if (addr == ADDR_SCTRL) begin
      dataOut[0] = s_rdy;
      dataOut[2] = s_ovr;
      dataOut[8] = s_ie;
    end
  end

endmodule

// File: tb/tb_io_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_io_input_ctrl
//
// Directed scenarios followed by randomized traffic for io_input_ctrl with
// DEBOUNCE_CYCLES=4. Expected values come from a behavioural model: the
// debouncer is modelled as a sliding window of synchronized samples that must
// all differ from the stable value since the last acceptance or reset.
// -----------------------------------------------------------------------------
module tb_io_input_ctrl;

  localparam int          DC    = 4;
  localparam logic [31:0] A_KEY = 32'hF0000010;
  localparam logic [31:0] A_SW  = 32'hF0000014;
  localparam logic [31:0] A_KC  = 32'hF0000110;
  localparam logic [31:0] A_SC  = 32'hF0000114;
`ifdef IO_INPUT_SW_DEBOUNCE_EN
  localparam int          SW_LAT = DC + 2;
`else
  localparam int          SW_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        rdEn = 1'b0;
  logic        wrEn = 1'b0;
  logic [31:0] dataIn = '0;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  SW = '0;
  logic [31:0] dataOut;
  logic        intr;

  always #5 clk = ~clk;

  io_input_ctrl #(
    .DBITS(32), .DEBOUNCE_CYCLES(DC),
    .ADDR_KEY(A_KEY), .ADDR_SW(A_SW), .ADDR_KCTRL(A_KC), .ADDR_SCTRL(A_SC)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .rdEn(rdEn), .wrEn(wrEn),
    .dataIn(dataIn), .KEY(KEY), .SW(SW), .dataOut(dataOut), .intr(intr)
  );

  // Reference model state
  logic [3:0] m_kpipe [2];
  logic [9:0] m_spipe [2];
  logic [3:0] m_kstab;
  logic [9:0] m_sstab;
  logic [3:0] m_kwin [$];
  logic [9:0] m_swin [$];
  logic       m_krdy, m_kovr, m_kie, m_srdy, m_sovr, m_sie, m_intr;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
  endtask

  function automatic logic [31:0] expRead(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a == A_KEY)      r = {28'b0, m_kstab};
    else if (a == A_SW)  r = {22'b0, m_sstab};
    else if (a == A_KC)  r = {23'b0, m_kie, 5'b0, m_kovr, 1'b0, m_krdy};
    else if (a == A_SC)  r = {23'b0, m_sie, 5'b0, m_sovr, 1'b0, m_srdy};
    return r;
  endfunction

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic modelStep();
    logic [3:0] kseen;
    logic [9:0] sseen;
    logic kupd, supd, rdk, rds, wrk, wrs, kov, sov;
    if (!reset) begin
      m_kpipe = '{4'hF, 4'hF};
      m_spipe = '{10'h0, 10'h0};
      m_kstab = 4'hF;
      m_sstab = '0;
      m_kwin.delete();
      m_swin.delete();
      {m_krdy, m_kovr, m_kie, m_srdy, m_sovr, m_sie, m_intr} = '0;
    end else begin
      m_intr = (m_krdy & m_kie) | (m_srdy & m_sie);

      kseen = m_kpipe[1];
      m_kpipe[1] = m_kpipe[0];
      m_kpipe[0] = KEY;
      m_kwin.push_back(kseen);
      if (m_kwin.size() > DC) m_kwin.delete(0);
      kupd = (m_kwin.size() == DC);
      foreach (m_kwin[i]) if (m_kwin[i] == m_kstab) kupd = 1'b0;
      if (kupd) begin
        m_kstab = kseen;
        m_kwin.delete();
      end

      sseen = m_spipe[1];
      m_spipe[1] = m_spipe[0];
      m_spipe[0] = SW;
`ifdef IO_INPUT_SW_DEBOUNCE_EN
      m_swin.push_back(sseen);
      if (m_swin.size() > DC) m_swin.delete(0);
      supd = (m_swin.size() == DC);
      foreach (m_swin[i]) if (m_swin[i] == m_sstab) supd = 1'b0;
      if (supd) begin
        m_sstab = sseen;
        m_swin.delete();
      end
`else
      supd = (sseen != m_sstab);
      m_sstab = sseen;
`endif

      rdk = rdEn && (addr == A_KEY);
      rds = rdEn && (addr == A_SW);
      wrk = wrEn && (addr == A_KC);
      wrs = wrEn && (addr == A_SC);
      kov = kupd && m_krdy && !rdk;
      sov = supd && m_srdy && !rds;

      m_krdy = kupd ? 1'b1 : (rdk ? 1'b0 : m_krdy);
      m_srdy = supd ? 1'b1 : (rds ? 1'b0 : m_srdy);
      m_kovr = kov ? 1'b1 : ((wrk && !dataIn[2]) ? 1'b0 : m_kovr);
      m_sovr = sov ? 1'b1 : ((wrs && !dataIn[2]) ? 1'b0 : m_sovr);
      if (wrk) m_kie = dataIn[8];
      if (wrs) m_sie = dataIn[8];
    end
  endtask

  // One clock cycle: drive on the falling edge, check just after the rising edge.
  task automatic applyStimulus(input logic rst, input logic [31:0] a, input logic rd,
                               input logic wr, input logic [31:0] din,
                               input logic [3:0] k, input logic [9:0] s);
    @(negedge clk);
    reset = rst; addr = a; rdEn = rd; wrEn = wr; dataIn = din; KEY = k; SW = s;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("dout", dataOut, expRead(a));
    checkOutput("intr", {31'b0, intr}, {31'b0, m_intr});
  endtask

  logic [3:0]  k_cur;
  logic [9:0]  s_cur;
  logic [31:0] ra;

  initial begin
    // Reset state
    applyStimulus(1'b0, A_KEY, 1'b0, 1'b0, '0, 4'hF, 10'h0);
    applyStimulus(1'b0, A_KEY, 1'b0, 1'b0, '0, 4'hF, 10'h0);
    checkOutput("rst_kdata", dataOut, 32'hF);
    applyStimulus(1'b0, A_KC, 1'b0, 1'b0, '0, 4'hF, 10'h0);
    checkOutput("rst_kctrl", dataOut, 32'h0);

    // Held KEY change: accepted exactly 2+DC edges after first sample
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, A_KEY, 1'b0, 1'b0, '0, 4'hE, 10'h0);
      if (i == DC + 1) checkOutput("lat_before", dataOut, 32'hF);
      if (i == DC + 2) checkOutput("lat_exact", dataOut, 32'hE);
    end
    applyStimulus(1'b1, A_KC, 1'b0, 1'b0, '0, 4'hE, 10'h0);
    checkOutput("krdy_set", dataOut, 32'h1);
    applyStimulus(1'b1, A_KEY, 1'b1, 1'b0, '0, 4'hE, 10'h0);
    applyStimulus(1'b1, A_KC, 1'b0, 1'b0, '0, 4'hE, 10'h0);
    checkOutput("krdy_clr", dataOut, 32'h0);

    // Glitch one cycle shorter than the debounce window
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, A_KC, 1'b0, 1'b0, '0, 4'hD, 10'h0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, A_KC, 1'b0, 1'b0, '0, 4'hE, 10'h0);
    checkOutput("glitch_kctrl", dataOut, 32'h0);
    applyStimulus(1'b1, A_KEY, 1'b0, 1'b0, '0, 4'hE, 10'h0);
    checkOutput("glitch_kdata", dataOut, 32'hE);

    // Read in the same cycle a new value is accepted
    for (int i = 1; i <= DC + 2; i++)
      applyStimulus(1'b1, A_KEY, (i == DC + 2), 1'b0, '0, 4'hC, 10'h0);
    applyStimulus(1'b1, A_KC, 1'b0, 1'b0, '0, 4'hC, 10'h0);
    checkOutput("rd_vs_upd", dataOut, 32'h1);
    applyStimulus(1'b1, A_KEY, 1'b1, 1'b0, '0, 4'hC, 10'h0);

    // Interrupt enable, raise and clear
    applyStimulus(1'b1, A_KC, 1'b0, 1'b1, 32'h100, 4'hC, 10'h0);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, A_KC, 1'b0, 1'b0, '0, 4'h8, 10'h0);
      if (i == DC + 2) checkOutput("intr_lag", {31'b0, intr}, 32'h0);
      if (i == DC + 3) checkOutput("intr_rise", {31'b0, intr}, 32'h1);
    end
    applyStimulus(1'b1, A_KEY, 1'b1, 1'b0, '0, 4'h8, 10'h0);
    checkOutput("intr_hold", {31'b0, intr}, 32'h1);
    applyStimulus(1'b1, A_KC, 1'b0, 1'b0, '0, 4'h8, 10'h0);
    checkOutput("intr_fall", {31'b0, intr}, 32'h0);

    // Two SW acceptances without a read give an overrun; write clears it
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, A_SC, 1'b0, 1'b0, '0, 4'h8, 10'h001);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, A_SC, 1'b0, 1'b0, '0, 4'h8, 10'h003);
    checkOutput("sctrl_ovr", dataOut, 32'h5);
    applyStimulus(1'b1, A_SC, 1'b0, 1'b1, 32'h0, 4'h8, 10'h003);
    checkOutput("sctrl_wr", dataOut, 32'h1);

    // Reset in the middle of a SW debounce
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, A_SW, 1'b0, 1'b0, '0, 4'h8, 10'h3FF);
    applyStimulus(1'b0, A_SW, 1'b0, 1'b0, '0, 4'h8, 10'h3FF);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, A_SW, 1'b0, 1'b0, '0, 4'h8, 10'h3FF);
      if (i == SW_LAT - 1) checkOutput("rst_sw_hold", dataOut, 32'h0);
      if (i == SW_LAT)     checkOutput("rst_sw_acc", dataOut, 32'h3FF);
    end

    // Randomized traffic
    k_cur = 4'h8;
    s_cur = 10'h3FF;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) k_cur = 4'($urandom);
      if ($urandom_range(0, 5) == 0) s_cur = 10'($urandom);
      case ($urandom_range(0, 5))
        0: ra = A_KEY;
        1: ra = A_SW;
        2: ra = A_KC;
        3: ra = A_SC;
        4: ra = 32'hF0000018;
        default: ra = $urandom;
      endcase
      applyStimulus(($urandom_range(0, 199) != 0), ra, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) == 0), $urandom, k_cur, s_cur);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
